avr_pp_sequencer: RTL and testbench

AVR_PP_SEQUENCER -- requirements
Module: avr_pp_sequencer

---
 rtl/avr_pp_sequencer.sv | 131 +++++++++++++
 tb/tb_avr_pp_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/avr_pp_sequencer.sv
// avr_pp_sequencer: AVR high-voltage parallel programming pin sequencer
module avr_pp_sequencer #(
  parameter int PULSE_CYCLES = 12,
  parameter int RDY_TIMEOUT = 24000
) (
  input  logic       osc_in,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       dut_xa0,
  output logic       dut_xa1,
  output logic       dut_bs1,
  output logic       dut_bs2,
  output logic       dut_xtal,
  output logic       dut_pagel,
  output logic       dut_oe,
  output logic       dut_wr,
  output logic [7:0] dut_dout,
  output logic       dut_dout_en,
  input  logic [7:0] dut_din,
  input  logic       dut_rdy
);
  typedef enum logic [3:0] {IDLE, SETUP, XTAL_HI, WR_LO, WR_REC, WAIT_RDY, OE_LO, PAGEL_HI, DONE} state_t;
  localparam logic [7:0] PL = 8'(PULSE_CYCLES - 1);
  localparam logic [19:0] TL = 20'(RDY_TIMEOUT - 1);
  state_t state;
  logic [2:0] op;
  logic [7:0] cnt;
  logic [19:0] tmo;
  logic last;
  assign cmd_ready = state == IDLE;
  assign last = cnt == 8'd0;
  // Sequencer: pins are set on the edge entering each state so they are stable for the whole state
  always_ff @(posedge osc_in) begin
    if (rst) begin
      state <= IDLE;
      op <= 3'd0;
      cnt <= 8'd0;
      tmo <= 20'd0;
      rsp_valid <= 1'b0;
      rsp_data <= 8'd0;
      rsp_err <= 1'b0;
      dut_xa0 <= 1'b0;
      dut_xa1 <= 1'b0;
      dut_bs1 <= 1'b0;
      dut_bs2 <= 1'b0;
      dut_xtal <= 1'b0;
      dut_pagel <= 1'b0;
      dut_oe <= 1'b1;
      dut_wr <= 1'b1;
      dut_dout <= 8'd0;
      dut_dout_en <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          op <= cmd_op;
          state <= SETUP;
          dut_dout_en <= cmd_op != 3'd6;
          if (cmd_op <= 3'd4) begin
            dut_xa1 <= cmd_op == 3'd0;
            dut_xa0 <= cmd_op >= 3'd3;
            dut_bs1 <= cmd_op == 3'd2 || cmd_op == 3'd4;
            dut_bs2 <= 1'b0;
            dut_dout <= cmd_data;
          end else if (cmd_op == 3'd6) begin
            dut_xa1 <= 1'b0;
            dut_xa0 <= 1'b0;
            dut_bs1 <= cmd_data[0];
            dut_bs2 <= cmd_data[1];
          end
        end
        SETUP: begin
          cnt <= PL;
          case (op)
            3'd5: begin dut_wr <= 1'b0; state <= WR_LO; end
            3'd6: begin dut_oe <= 1'b0; state <= OE_LO; end
            3'd7: begin dut_pagel <= 1'b1; state <= PAGEL_HI; end
            default: begin dut_xtal <= 1'b1; state <= XTAL_HI; end
          endcase
        end
        XTAL_HI: if (last) begin
          dut_xtal <= 1'b0;
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_data <= 8'd0;
        end else cnt <= cnt - 8'd1;
        WR_LO: if (last) begin
          dut_wr <= 1'b1;
          cnt <= PL;
          state <= WR_REC;
        end else cnt <= cnt - 8'd1;
        WR_REC: if (last) begin
          tmo <= 20'd0;
          state <= WAIT_RDY;
        end else cnt <= cnt - 8'd1;
        WAIT_RDY: if (dut_rdy || tmo == TL) begin
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_err <= !dut_rdy;
          rsp_data <= 8'd0;
        end else tmo <= tmo + 20'(tmo != '1);
        OE_LO: if (last) begin
          dut_oe <= 1'b1;
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_data <= dut_din;
        end else cnt <= cnt - 8'd1;
        PAGEL_HI: if (last) begin
          dut_pagel <= 1'b0;
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_data <= 8'd0;
        end else cnt <= cnt - 8'd1;
        DONE: begin
          state <= IDLE;
          dut_dout_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avr_pp_sequencer.sv
// tb_avr_pp_sequencer: scoreboard bench for the parallel programming sequencer
module tb_avr_pp_sequencer;
  logic clk = 0, rst = 1, cmd_valid = 0, dut_rdy = 1;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_data = 0, dut_din = 0;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_data, dut_dout;
  logic dut_xa0, dut_xa1, dut_bs1, dut_bs2, dut_xtal, dut_pagel, dut_oe, dut_wr, dut_dout_en;

  avr_pp_sequencer #(.PULSE_CYCLES(12), .RDY_TIMEOUT(50)) dut (
    .osc_in(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .dut_xa0(dut_xa0), .dut_xa1(dut_xa1), .dut_bs1(dut_bs1),
    .dut_bs2(dut_bs2), .dut_xtal(dut_xtal), .dut_pagel(dut_pagel), .dut_oe(dut_oe),
    .dut_wr(dut_wr), .dut_dout(dut_dout), .dut_dout_en(dut_dout_en),
    .dut_din(dut_din), .dut_rdy(dut_rdy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  typedef struct {logic [7:0] d; logic e; int lat;} exp_t;
  exp_t exp_q[$];
  int acc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic active(input int s);
    return s == 0 ? dut_xtal : s == 1 ? !dut_wr : s == 2 ? !dut_oe : dut_pagel;
  endfunction

  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] ed, input logic ee, input int lat);
    int n = 0;
    exp_t e;
    e.d = ed; e.e = ee; e.lat = lat;
    exp_q.push_back(e);
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 300) begin tick; n++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
    end
    tick;
  endtask

  task automatic measure(input int sel, output int w, output logic en);
    int n = 0;
    w = 0; en = 0;
    while (!active(sel) && n < 300) begin tick; n++; end
    while (active(sel) && w < 300) begin en |= dut_dout_en; w++; tick; end
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick; n++; end
    chk("pending_responses", exp_q.size(), 0);
  endtask

  // Monitor: records acceptances, pops the scoreboard on every response, watches bus contention
  always @(negedge clk) begin
    exp_t e;
    int a;
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no pending command");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_err", rsp_err, e.e);
          if (e.lat >= 0) chk("rsp_latency", cyc - a, e.lat);
        end
      end
      if (!dut_oe) chk("dout_en_while_oe_low", dut_dout_en, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic en;
    repeat (3) tick;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr", dut_wr, 1);
    chk("rst_oe", dut_oe, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dout_en", dut_dout_en, 0);
    chk("rst_pins", {dut_xtal, dut_pagel, dut_xa0, dut_xa1, dut_bs1, dut_bs2, dut_dout}, 0);
    rst = 0;
    tick;
    send(3'd0, 8'h20, 8'h00, 0, 14);
    chk("load_cmd_xa1", dut_xa1, 1);
    chk("load_cmd_xa0", dut_xa0, 0);
    chk("load_cmd_bs1", dut_bs1, 0);
    chk("load_cmd_dout", dut_dout, 8'h20);
    chk("load_cmd_dout_en", dut_dout_en, 1);
    cmd_valid = 0;
    measure(0, w, en);
    chk("xtal_width", w, 12);
    chk("load_cmd_hold_dout", dut_dout, 8'h20);
    drain;
    chk("idle_dout_en", dut_dout_en, 0);
    send(3'd4, 8'h3C, 8'h00, 0, 14);
    cmd_valid = 0;
    chk("load_dhi_pins", {dut_xa1, dut_xa0, dut_bs1, dut_dout}, {3'b011, 8'h3C});
    drain;
    dut_rdy = 0;
    send(3'd5, 8'h00, 8'h00, 0, 45);
    cmd_valid = 0;
    measure(1, w, en);
    chk("wr_width", w, 12);
    repeat (30) tick;
    dut_rdy = 1;
    drain;
    dut_rdy = 0;
    send(3'd5, 8'h00, 8'h00, 1, 76);
    cmd_valid = 0;
    drain;
    dut_rdy = 1;
    dut_din = 8'hA5;
    send(3'd6, 8'h01, 8'hA5, 0, 14);
    cmd_valid = 0;
    chk("read_pins", {dut_xa1, dut_xa0, dut_bs1, dut_bs2, dut_dout_en}, 5'b00100);
    measure(2, w, en);
    chk("oe_width", w, 12);
    chk("read_dout_en_seen", en, 0);
    dut_din = 8'h00;
    drain;
    send(3'd7, 8'h00, 8'h00, 0, 14);
    cmd_valid = 0;
    measure(3, w, en);
    chk("pagel_width", w, 12);
    drain;
    dut_rdy = 0;
    send(3'd5, 8'h00, 8'h00, 0, -1);
    cmd_valid = 0;
    repeat (3) tick;
    chk("abort_in_wr_lo", dut_wr, 0);
    rst = 1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    tick;
    rst = 0;
    chk("abort_wr", dut_wr, 1);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_dout", {dut_dout_en, dut_dout}, 0);
    repeat (20) tick;
    dut_rdy = 1;
    send(3'd1, 8'h11, 8'h00, 0, 14);
    cmd_valid = 0;
    chk("load_alo_pins", {dut_xa1, dut_xa0, dut_bs1, dut_dout}, {3'b000, 8'h11});
    drain;
    send(3'd2, 8'h5A, 8'h00, 0, 14);
    chk("stream_ahi", {dut_xa1, dut_xa0, dut_bs1, dut_dout}, {3'b001, 8'h5A});
    send(3'd3, 8'hC3, 8'h00, 0, 14);
    chk("stream_dlo", {dut_xa1, dut_xa0, dut_bs1, dut_dout}, {3'b010, 8'hC3});
    send(3'd7, 8'h00, 8'h00, 0, 14);
    chk("stream_pagel_hold", dut_dout, 8'hC3);
    send(3'd0, 8'h80, 8'h00, 0, 14);
    chk("stream_cmd", {dut_xa1, dut_xa0, dut_dout}, {2'b10, 8'h80});
    cmd_valid = 0;
    drain;
    repeat (5) tick;
    chk("leftover_accepts", acc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
